fifo_word_serializer: RTL and testbench
=======================================

# fifo_word_serializer

Downstream drain stage for the 64-bit shift-register FIFO: pops one word at a time via the FIFO's push/pop/empty interface and emits it as a sequence of narrower beats on a valid/ready output channel. It sits between the FIFO and a narrow link or bus interface. It converts the FIFO's combinational head-of-queue output into a registered, back-pressure-aware beat stream.

## Interface
- MSBD, 63, MSB of FIFO word; must match the FIFO's data parameter.
- MSBO, 15, MSB of output beat; (MSBD+1) must be an integer multiple of (MSBO+1).
- BEATS, (MSBD+1)/(MSBO+1) = 4, beats per word; derived, not overridden.
- clock  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- fifoData  in  MSBD+1  FIFO head word (FIFO dataOut); valid whenever fifoEmpty=0.
- fifoEmpty  in  1  FIFO empty flag.
- fifoPop  out  1  pop request to FIFO; combinational.
- beatData  out  MSBO+1  current beat; registered.
- beatValid  out  1  beatData is valid; registered.
- beatLast  out  1  current beat is the final beat of its word; registered.
- beatReady  in  1  consumer accepts the beat when beatValid & beatReady at posedge.
- busy  out  1  a word is held (state SEND); registered.

## Operation
- States: IDLE (no word held), SEND (word held, beats outstanding).
- Word register W[MSBD:0] and beat index idx (0..BEATS-1, width ceil(log2(BEATS)), min 1 bit).
- Pop condition (combinational): fifoPop = ~fifoEmpty & (IDLE | (SEND & beatReady & idx==BEATS-1)). Never asserted when fifoEmpty=1.
- On pop: W <= fifoData, idx <= 0, state <= SEND.
- In SEND, accepted beat with idx<BEATS-1: idx <= idx+1. No FIFO interaction.
- In SEND, accepted last beat with no pop (FIFO empty): state <= IDLE.
- beatData = W[(idx+1)*(MSBO+1)-1 : idx*(MSBO+1)]; beats go out LSB-first.
- beatLast = (idx==BEATS-1) & SEND; beatValid = SEND; busy = SEND.
- beatData/beatLast stay constant while beatValid=1 and beatReady=0. beatValid never drops without acceptance.
- beatReady while beatValid=0 is ignored.
- The block never pushes. It treats the FIFO as drained only via fifoPop.

## Timing
- Reset (async assert, synchronous deassert handled upstream): state=IDLE, idx=0, W=0. Outputs: beatValid=0, beatLast=0, busy=0, beatData=0, fifoPop=0 (forced while rst=1).
- Reset mid-word: any held word and remaining beats are discarded. The word already popped is not returned to the FIFO.
- Latency: word present (fifoEmpty=0) in IDLE at cycle N → fifoPop=1 in cycle N → beat 0 valid in cycle N+1.
- Throughput: with beatReady held 1 and FIFO non-empty, one beat per cycle with no bubble between words. The last beat of word k and the pop of word k+1 share a cycle.
- The FIFO updates tail/empty at the same posedge on which fifoPop is sampled, so fifoData is captured before the FIFO advances.
- A push to the FIFO in the same cycle is the FIFO's concern. This block only observes fifoEmpty of the current cycle.

## Structure
- Shared package holds the state encoding (IDLE=1'b0, SEND=1'b1) and the derived BEATS/index-width constants, so that a future matching upstream deserializer can reuse them.
- Single module, no sub-module. The beat mux is an indexed part-select on W.

## Test plan
- Reset then idle: rst pulse with fifoEmpty=1 for 10 cycles → fifoPop=0, beatValid=0, busy=0 throughout.
- Single word, ready=1: FIFO holds 64'h0123_4567_89AB_CDEF → fifoPop for 1 cycle, then beats 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123 on 4 consecutive cycles. beatLast only on 16'h0123; then IDLE.
- Back-pressure: same word, beatReady low for 3 cycles during beat 16'h89AB → beatData holds 16'h89AB, beatValid=1, and no second pop occurs.
- Back-to-back words: FIFO holds 3 words, beatReady=1 → 12 consecutive valid beats. fifoPop is high in cycles 0, 4 and 8 relative to the first pop.
- Reset mid-operation: assert rst after beat 1 of a word → beatValid=0 immediately. After release, the next FIFO word starts at its beat 0.
- Random stall: random beatReady and random FIFO push pattern over 500 words → reassembled stream equals the pushed sequence with no loss or duplication, and fifoPop is never high while fifoEmpty=1.

Source files
------------

// File: rtl/fifo_word_serializer_pkg.sv
// rtl/fifo_word_serializer_pkg.sv - shared state encoding and beat-count helpers for word serializers
//
// Purpose: holds the serializer state encoding and the derived beat-count /
// beat-index-width constants so a matching upstream deserializer can reuse them.
// Ports: none (package).

package fifo_word_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,   // no word held
    SEND = 1'b1    // word held, beats outstanding
  } ser_state_t;

  localparam int DEF_MSBD = 63;
  localparam int DEF_MSBO = 15;

  // Beats per word for a given word MSB and beat MSB.
  function automatic int beats_of(input int msbd, input int msbo);
    return (msbd + 1) / (msbo + 1);
  endfunction

  // Width of a beat index; at least one bit even for a single-beat word.
  function automatic int idx_width(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

  localparam int BEATS = beats_of(DEF_MSBD, DEF_MSBO);
  localparam int IDXW  = idx_width(BEATS);

endpackage

// File: rtl/fifo_word_serializer.sv
// rtl/fifo_word_serializer.sv - pops FIFO words and emits them LSB-first as narrow valid/ready beats
//
// Purpose: drain stage for the shift-register FIFO. Captures the FIFO head word
// on a pop and emits it as BEATS narrower beats with back-pressure.
// Ports:
//   clock      in   single clock, posedge
//   rst        in   asynchronous active-high reset
//   fifoData   in   FIFO head word, valid whenever fifoEmpty=0
//   fifoEmpty  in   FIFO empty flag
//   fifoPop    out  pop request to the FIFO (combinational)
//   beatData   out  current beat (from registered word/index)
//   beatValid  out  beatData is valid
//   beatLast   out  current beat is the last of its word
//   beatReady  in   consumer accepts the beat on beatValid & beatReady
//   busy       out  a word is held

import fifo_word_serializer_pkg::*;

module fifo_word_serializer #(
  parameter int MSBD = 63,
  parameter int MSBO = 15
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [MSBD:0] fifoData,
  input  logic          fifoEmpty,
  output logic          fifoPop,
  output logic [MSBO:0] beatData,
  output logic          beatValid,
  output logic          beatLast,
  input  logic          beatReady,
  output logic          busy
);

  localparam int NBEATS = beats_of(MSBD, MSBO);
  localparam int IW     = idx_width(NBEATS);
  localparam int BW     = MSBO + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBEATS - 1);

  ser_state_t    state_q, state_d;
  logic [MSBD:0] word_q, word_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          accept;
  logic          at_last;
  logic          pop;

  assign accept  = (state_q == SEND) & beatReady;
  assign at_last = (idx_q == LAST_IDX);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    // A new word is taken either from IDLE or in the same cycle the last beat
    // of the current word is accepted, so back-to-back words have no bubble.
    pop     = ~fifoEmpty & ((state_q == IDLE) | (accept & at_last));
    if (pop) begin
      word_d  = fifoData;
      idx_d   = '0;
      state_d = SEND;
    end else if (accept) begin
      if (at_last) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Held low during reset so the FIFO never loses a word the block cannot keep.
  assign fifoPop   = pop & ~rst;

  assign beatData  = word_q[idx_q*BW +: BW];
  assign beatValid = (state_q == SEND);
  assign beatLast  = (state_q == SEND) & at_last;
  assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb/tb_fifo_word_serializer.sv - self-checking bench for fifo_word_serializer

module tb_fifo_word_serializer;

  logic        clock;
  logic        rst;
  logic [63:0] fifoData;
  logic        fifoEmpty;
  logic        fifoPop;
  logic [15:0] beatData;
  logic        beatValid;
  logic        beatLast;
  logic        beatReady;
  logic        busy;

  int n_checks;
  int n_fail;

  logic [63:0] q[$];

  fifo_word_serializer #(.MSBD(63), .MSBO(15)) dut (
    .clock    (clock),
    .rst      (rst),
    .fifoData (fifoData),
    .fifoEmpty(fifoEmpty),
    .fifoPop  (fifoPop),
    .beatData (beatData),
    .beatValid(beatValid),
    .beatLast (beatLast),
    .beatReady(beatReady),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          push;
    logic [63:0] pword;
    bit          ready;
    bit          e_pop;
    bit          e_valid;
    logic [15:0] e_data;
    bit          e_last;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifoEmpty = (q.size() == 0);
    fifoData  = (q.size() == 0) ? 64'h0 : q[0];
  endtask

  // Advance one clock; the model FIFO pops only after the DUT has sampled fifoData.
  task automatic tick();
    logic popped;
    popped = fifoPop;
    if (popped && q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pop_when_empty: fifoPop=1 with fifoEmpty=1 at %0t", $time);
    end
    @(posedge clock);
    #1;
    if (popped && q.size() != 0) void'(q.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_pop", {63'd0, fifoPop}, 64'd0);
    check("rst_valid", {63'd0, beatValid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clock);
    #1;
    check("rst_data", {48'd0, beatData}, 64'd0);
    check("rst_last", {63'd0, beatLast}, 64'd0);
    rst = 1'b0;
  endtask

  logic [63:0] bw[3];
  logic [63:0] sent[$];
  logic [63:0] asm_word;
  int          asm_n;
  int          words_pushed;
  int          words_got;
  int          cyc;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    beatReady = 1'b0;
    refresh();

    vecs[0]  = '{1, 64'h0123_4567_89AB_CDEF, 1, 1, 0, 16'h0000, 0};
    vecs[1]  = '{0, 64'h0, 1, 0, 1, 16'hCDEF, 0};
    vecs[2]  = '{0, 64'h0, 1, 0, 1, 16'h89AB, 0};
    vecs[3]  = '{0, 64'h0, 1, 0, 1, 16'h4567, 0};
    vecs[4]  = '{0, 64'h0, 1, 0, 1, 16'h0123, 1};
    vecs[5]  = '{0, 64'h0, 1, 0, 0, 16'h0000, 0};
    vecs[6]  = '{1, 64'h0123_4567_89AB_CDEF, 1, 1, 0, 16'h0000, 0};
    vecs[7]  = '{0, 64'h0, 1, 0, 1, 16'hCDEF, 0};
    vecs[8]  = '{1, 64'hFEDC_BA98_7654_3210, 0, 0, 1, 16'h89AB, 0};
    vecs[9]  = '{0, 64'h0, 0, 0, 1, 16'h89AB, 0};
    vecs[10] = '{0, 64'h0, 0, 0, 1, 16'h89AB, 0};
    vecs[11] = '{0, 64'h0, 1, 0, 1, 16'h89AB, 0};
    vecs[12] = '{0, 64'h0, 1, 0, 1, 16'h4567, 0};
    vecs[13] = '{0, 64'h0, 1, 1, 1, 16'h0123, 1};
    vecs[14] = '{0, 64'h0, 1, 0, 1, 16'h3210, 0};
    vecs[15] = '{0, 64'h0, 1, 0, 1, 16'h7654, 0};
    vecs[16] = '{0, 64'h0, 1, 0, 1, 16'hBA98, 0};
    vecs[17] = '{0, 64'h0, 1, 0, 1, 16'hFEDC, 1};
    vecs[18] = '{0, 64'h0, 1, 0, 0, 16'h0000, 0};

    // Reset then idle with an empty FIFO.
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      beatReady = i[0];
      #2;
      check("idle_pop", {63'd0, fifoPop}, 64'd0);
      check("idle_valid", {63'd0, beatValid}, 64'd0);
      check("idle_busy", {63'd0, busy}, 64'd0);
      tick();
    end

    // Table: single word, then back-pressure with a second word queued.
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].push) q.push_back(vecs[i].pword);
      refresh();
      beatReady = vecs[i].ready;
      #2;
      check($sformatf("vec%0d_pop", i), {63'd0, fifoPop}, {63'd0, vecs[i].e_pop});
      check($sformatf("vec%0d_valid", i), {63'd0, beatValid}, {63'd0, vecs[i].e_valid});
      check($sformatf("vec%0d_busy", i), {63'd0, busy}, {63'd0, vecs[i].e_valid});
      check($sformatf("vec%0d_last", i), {63'd0, beatLast}, {63'd0, vecs[i].e_last});
      if (vecs[i].e_valid)
        check($sformatf("vec%0d_data", i), {48'd0, beatData}, {48'd0, vecs[i].e_data});
      tick();
    end

    // Back-to-back words: pops at relative cycles 0, 4, 8 and 12 valid beats.
    bw[0] = 64'h1111_2222_3333_4444;
    bw[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    bw[2] = 64'h0F0F_F0F0_5A5A_A5A5;
    for (int i = 0; i < 3; i++) q.push_back(bw[i]);
    refresh();
    beatReady = 1'b1;
    for (int c = 0; c < 14; c++) begin
      logic [63:0] w;
      #2;
      check($sformatf("b2b%0d_pop", c), {63'd0, fifoPop}, {63'd0, (c == 0 || c == 4 || c == 8)});
      check($sformatf("b2b%0d_valid", c), {63'd0, beatValid}, {63'd0, (c >= 1 && c <= 12)});
      if (c >= 1 && c <= 12) begin
        w = bw[(c - 1) / 4];
        check($sformatf("b2b%0d_data", c), {48'd0, beatData}, {48'd0, w[((c - 1) % 4) * 16 +: 16]});
        check($sformatf("b2b%0d_last", c), {63'd0, beatLast}, {63'd0, ((c - 1) % 4) == 3});
      end
      tick();
    end

    // Reset mid-word: the held word is dropped, the next FIFO word starts at beat 0.
    q.push_back(64'hDEAD_BEEF_CAFE_F00D);
    q.push_back(64'h7777_6666_5555_4444);
    refresh();
    beatReady = 1'b1;
    #2;
    check("mid_pop0", {63'd0, fifoPop}, 64'd1);
    tick();
    #2;
    check("mid_beat0", {48'd0, beatData}, 64'h0000_0000_0000_F00D);
    tick();
    #2;
    check("mid_beat1", {48'd0, beatData}, 64'h0000_0000_0000_CAFE);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, beatValid}, 64'd0);
    check("mid_rst_pop", {63'd0, fifoPop}, 64'd0);
    tick();
    check("mid_rst_depth", 64'(q.size()), 64'd1);
    rst = 1'b0;
    #2;
    check("mid_after_pop", {63'd0, fifoPop}, 64'd1);
    tick();
    #2;
    check("mid_after_valid", {63'd0, beatValid}, 64'd1);
    check("mid_after_beat0", {48'd0, beatData}, 64'h0000_0000_0000_4444);
    check("mid_after_last", {63'd0, beatLast}, 64'd0);
    beatReady = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("mid_drained_busy", {63'd0, busy}, 64'd0);

    // Random stall and random push pattern over 500 words.
    words_pushed = 0;
    words_got    = 0;
    asm_word     = '0;
    asm_n        = 0;
    cyc          = 0;
    while (words_got < 500 && cyc < 20000) begin
      if (words_pushed < 500 && $urandom_range(0, 2) != 0) begin
        logic [63:0] nw;
        nw = {$urandom, $urandom};
        q.push_back(nw);
        sent.push_back(nw);
        words_pushed++;
      end
      refresh();
      beatReady = ($urandom_range(0, 3) != 0);
      #2;
      if (beatValid && beatReady) begin
        asm_word[asm_n * 16 +: 16] = beatData;
        if (beatLast != (asm_n == 3)) begin
          check("rnd_last_pos", {63'd0, beatLast}, {63'd0, (asm_n == 3)});
        end
        if (asm_n == 3) begin
          if (sent.size() == 0) begin
            check("rnd_extra_word", 64'd1, 64'd0);
          end else begin
            check($sformatf("rnd_word%0d", words_got), asm_word, sent.pop_front());
          end
          words_got++;
          asm_n = 0;
        end else begin
          asm_n++;
        end
      end
      tick();
      cyc++;
    end
    check("rnd_words_received", 64'(words_got), 64'd500);
    check("rnd_nothing_left", 64'(sent.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
